// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: payload + control word, valid/ready flow
// control, optional 2-entry skid buffer, synchronous flush, bubble ctrl zeroing.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 20,
  parameter int SKID   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              I_VALID,
  output logic              O_READY,
  input  logic [DATA_W-1:0] I_DATA,
  input  logic [CTRL_W-1:0] I_CTRL,
  output logic              O_VALID,
  input  logic              I_READY,
  output logic [DATA_W-1:0] O_DATA,
  output logic [CTRL_W-1:0] O_CTRL,
  output logic [1:0]        O_COUNT
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  ent_t main_q, main_d;
  ent_t skid_q, skid_d;
  ent_t in_e;
  logic main_v, main_vd;
  logic skid_v, skid_vd;
  logic accept, consume;

  assign in_e = {I_DATA, I_CTRL};

  // With a skid slot, ready comes from a flop only; without, it looks through.
  assign O_READY = (SKID != 0) ? !skid_v : (!main_v | I_READY);

  assign accept  = I_VALID & O_READY;
  assign consume = main_v & I_READY;

  always_comb begin
    main_vd = main_v;
    main_d  = main_q;
    skid_vd = skid_v;
    skid_d  = skid_q;
    if (FLUSH) begin
      main_vd = 1'b0;
      skid_vd = 1'b0;
    end else if (skid_v) begin
      if (consume) begin
        main_d  = skid_q;
        skid_vd = 1'b0;
      end
    end else if (!main_v || consume) begin
      main_vd = accept;
      if (accept) main_d = in_e;
    end else if (accept && SKID != 0) begin
      skid_vd = 1'b1;
      skid_d  = in_e;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v <= main_vd;
      skid_v <= skid_vd;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign O_VALID = main_v;
  assign O_DATA  = main_q.data;
  assign O_CTRL  = main_v ? main_q.ctrl : '0;
  assign O_COUNT = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 and SKID=1 instances share stimulus and
// are each checked every cycle against a queue model of the stage.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fl = 1'b0;
  logic        iv = 1'b0;
  logic        ir = 1'b0;
  logic [95:0] din = '0;
  logic [19:0] cin = '0;

  logic        ov[2];
  logic        ordy[2];
  logic [95:0] od[2];
  logic [19:0] oc[2];
  logic [1:0]  cnt[2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(20), .SKID(0)) u_noskid (
    .CLK(clk), .RESET(rst), .FLUSH(fl),
    .I_VALID(iv), .O_READY(ordy[0]),
    .I_DATA(din), .I_CTRL(cin),
    .O_VALID(ov[0]), .I_READY(ir),
    .O_DATA(od[0]), .O_CTRL(oc[0]), .O_COUNT(cnt[0])
  );

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(20), .SKID(1)) u_skid (
    .CLK(clk), .RESET(rst), .FLUSH(fl),
    .I_VALID(iv), .O_READY(ordy[1]),
    .I_DATA(din), .I_CTRL(cin),
    .O_VALID(ov[1]), .I_READY(ir),
    .O_DATA(od[1]), .O_CTRL(oc[1]), .O_COUNT(cnt[1])
  );

  // Model: an ordered list of held entries, capacity 2 (k=1) or 1 (k=0).
  typedef struct packed {
    logic [95:0] d;
    logic [19:0] c;
  } ent_t;

  ent_t        mq[2][2];
  int          msz[2];
  logic [95:0] mlast[2];

  function automatic logic exp_rdy(int k, int sz, logic r);
    return (k == 1) ? (sz < 2) : (sz == 0 || r);
  endfunction

  always @(posedge clk or posedge rst) begin
    ent_t a0, a1;
    int   n;
    logic acc, con;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        msz[k]   <= 0;
        mlast[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        a0 = mq[k][0];
        a1 = mq[k][1];
        n  = msz[k];
        if (fl) begin
          n = 0;
        end else begin
          acc = iv && exp_rdy(k, n, ir);
          con = (n > 0) && ir;
          if (con) begin
            a0 = a1;
            n  = n - 1;
          end
          if (acc) begin
            if (n == 0) a0 = {din, cin};
            else        a1 = {din, cin};
            n = n + 1;
          end
        end
        mq[k][0] <= a0;
        mq[k][1] <= a1;
        msz[k]   <= n;
        if (n > 0) mlast[k] <= a0.d;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic        ev;
    logic [19:0] ec;
    logic [95:0] ed;
    for (int k = 0; k < 2; k++) begin
      ev = (msz[k] > 0);
      ec = ev ? mq[k][0].c : 20'h0;
      ed = ev ? mq[k][0].d : mlast[k];
      chk($sformatf("k%0d valid", k), 128'(ov[k]), 128'(ev));
      chk($sformatf("k%0d ctrl", k), 128'(oc[k]), 128'(ec));
      chk($sformatf("k%0d data", k), 128'(od[k]), 128'(ed));
      chk($sformatf("k%0d count", k), 128'(cnt[k]), 128'(msz[k]));
      chk($sformatf("k%0d ready", k), 128'(ordy[k]),
          128'(exp_rdy(k, msz[k], ir)));
    end
  endtask

  task automatic drive(input logic rs, input logic v, input logic r,
                       input logic f, input logic [95:0] d,
                       input logic [19:0] c);
    @(posedge clk);
    #1;
    rst = rs;
    iv  = v;
    ir  = r;
    fl  = f;
    din = d;
    cin = c;
    @(negedge clk);
    cmp_model();
  endtask

  initial begin
    repeat (3) drive(1, 0, 0, 0, '0, '0);
    chk("rst valid", 128'(ov[1]), 128'(0));
    chk("rst count", 128'(cnt[1]), 128'(0));
    chk("rst ready", 128'(ordy[1]), 128'(1));

    // mid-stream reset
    drive(0, 1, 0, 0, 96'h55, 20'h3);
    drive(0, 1, 0, 0, 96'h66, 20'h4);
    drive(0, 0, 0, 0, '0, '0);
    chk("pre-rst count", 128'(cnt[1]), 128'(2));
    drive(1, 1, 1, 0, 96'h77, 20'h5);
    chk("in-rst valid", 128'(ov[1]), 128'(0));
    chk("in-rst ctrl", 128'(oc[1]), 128'(0));
    chk("in-rst data", 128'(od[1]), 128'(0));

    // streaming 1,2,3
    drive(0, 1, 1, 0, 96'h1, 20'h11);
    drive(0, 1, 1, 0, 96'h2, 20'h12);
    chk("stream d1", 128'(od[1]), 128'(1));
    drive(0, 1, 1, 0, 96'h3, 20'h13);
    chk("stream d2", 128'(od[1]), 128'(2));
    chk("stream cnt", 128'(cnt[1]), 128'(1));
    drive(0, 0, 1, 0, '0, '0);
    chk("stream d3", 128'(od[1]), 128'(3));
    chk("stream c3", 128'(oc[1]), 128'(20'h13));
    drive(0, 0, 1, 0, '0, '0);
    chk("stream end", 128'(ov[1]), 128'(0));

    // backpressure into skid
    drive(0, 1, 0, 0, 96'hA, 20'h1);
    drive(0, 1, 0, 0, 96'hB, 20'h2);
    drive(0, 0, 0, 0, '0, '0);
    chk("bp count", 128'(cnt[1]), 128'(2));
    chk("bp ready", 128'(ordy[1]), 128'(0));
    chk("bp data", 128'(od[1]), 128'(96'hA));
    drive(0, 0, 1, 0, '0, '0);
    chk("bp head", 128'(od[1]), 128'(96'hA));
    drive(0, 0, 1, 0, '0, '0);
    chk("bp second", 128'(od[1]), 128'(96'hB));
    chk("bp ready1", 128'(ordy[1]), 128'(1));
    drive(0, 0, 1, 0, '0, '0);
    chk("bp drained", 128'(ov[1]), 128'(0));

    // bubble ctrl zeroing
    drive(0, 1, 1, 0, 96'hC0DE, 20'hFFFFF);
    drive(0, 0, 1, 0, '0, '0);
    chk("bub ctrl", 128'(oc[1]), 128'(20'hFFFFF));
    drive(0, 0, 1, 0, '0, '0);
    chk("bub zero", 128'(oc[1]), 128'(0));
    chk("bub data", 128'(od[1]), 128'(96'hC0DE));

    // flush with simultaneous accept and consume
    drive(0, 1, 0, 0, 96'hC, 20'h7);
    drive(0, 1, 0, 0, 96'hD, 20'h8);
    drive(0, 1, 1, 1, 96'hE, 20'h9);
    chk("fl pre", 128'(cnt[1]), 128'(2));
    drive(0, 0, 1, 0, '0, '0);
    chk("fl valid", 128'(ov[1]), 128'(0));
    chk("fl count", 128'(cnt[1]), 128'(0));
    chk("fl ready", 128'(ordy[1]), 128'(1));
    drive(0, 0, 1, 0, '0, '0);
    chk("fl no E", 128'(ov[1]), 128'(0));

    // single-entry mode, combinational ready
    drive(0, 1, 1, 1, '0, '0);
    drive(0, 1, 0, 0, 96'hF, 20'h1);
    drive(0, 0, 0, 0, '0, '0);
    chk("s0 ready0", 128'(ordy[0]), 128'(0));
    drive(0, 1, 1, 0, 96'h10, 20'h2);
    chk("s0 ready1", 128'(ordy[0]), 128'(1));
    chk("s0 head", 128'(od[0]), 128'(96'hF));
    drive(0, 0, 1, 0, '0, '0);
    chk("s0 next", 128'(od[0]), 128'(96'h10));
    chk("s0 cnt", 128'(cnt[0]), 128'(1));
    drive(0, 0, 1, 0, '0, '0);
    chk("s0 empty", 128'(ov[0]), 128'(0));

    // random soak
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 1999) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 39) == 0),
            {$urandom, $urandom, $urandom},
            20'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register. Successor to the fixed-width per-stage latches (ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload plus a control word.
- Adds valid/ready flow control, an optional 2-entry skid buffer, synchronous flush, and bubble control-zeroing.
- Sits between any two pipeline stages. The hazard unit drives FLUSH; the downstream stage drives I_READY in place of a global ENABLE.

Parameters:
- DATA_W, 96: payload width (e.g. PC + ALU result + store data).
- CTRL_W, 20: control-word width; forced to 0 on bubbles.
- SKID, 1: 1 = 2-entry skid buffer with registered O_READY; 0 = single entry with combinational O_READY.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous; discards all held entries.
- I_VALID  in  1  upstream offers an entry.
- O_READY  out  1  stage accepts an entry this cycle.
- I_DATA  in  DATA_W  upstream payload.
- I_CTRL  in  CTRL_W  upstream control word.
- O_VALID  out  1  output entry valid.
- I_READY  in  1  downstream consumes the output this cycle.
- O_DATA  out  DATA_W  output payload.
- O_CTRL  out  CTRL_W  output control word; 0 whenever O_VALID=0.
- O_COUNT  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Handshake events:
  - Accept = I_VALID & O_READY.
  - Consume = O_VALID & I_READY.
  - Both evaluated at the rising edge of CLK.
- Storage: main register (drives the outputs) and, when SKID=1, one skid register. FIFO order is strictly preserved.
- SKID=1:
  - O_READY = !skid_valid. It depends on registers only, with no combinational path from I_READY.
  - Main empty, or consumed while skid empty: an accepted entry loads main.
  - Main full and not consumed: an accepted entry loads skid.
  - Main consumed while skid full: skid moves to main and skid empties. No accept is possible that cycle because O_READY=0.
- SKID=0:
  - O_READY = !O_VALID | I_READY (combinational).
  - An accept loads main.
  - Consume without accept sets O_VALID=0.
- Latency: an accepted entry appears on O_DATA/O_CTRL the cycle after acceptance if it goes straight to main.
- Throughput: 1 entry/cycle when I_READY is held high.
- Bubble:
  - Whenever O_VALID=0, O_CTRL reads 0. Downstream write-enables and mem-writes are therefore inert.
  - O_DATA holds its last value; it is not cleared.
- FLUSH:
  - Next edge: O_VALID=0, skid emptied, O_COUNT=0, O_CTRL=0.
  - Overrides a simultaneous accept (the incoming entry is dropped) and a simultaneous consume (no effect beyond the flush).
  - O_READY=1 the cycle after FLUSH.
- RESET (asynchronous, any time including mid-transfer):
  - Outputs: O_VALID=0, O_DATA=0, O_CTRL=0, O_COUNT=0.
  - Skid contents cleared; O_READY=1 (SKID=1) or 1 by the combinational equation (SKID=0).
  - No entry survives reset.
- O_COUNT equals main_valid + skid_valid and never exceeds 2. An accept while full cannot occur, so there is no overflow path.
- Widths: there is no arithmetic. Payload and control pass through bit-exact.

Test Plan:
- Reset then streaming (SKID=1): assert RESET mid-stream. Then I_READY=1 and push I_DATA 0x1, 0x2, 0x3 on consecutive cycles. Required: O_VALID=0 and O_CTRL=0 during reset; outputs 0x1, 0x2, 0x3 one cycle after each accept; O_COUNT stays at 1.
- Backpressure/skid: I_READY=0 and push A=0xA, B=0xB. Required: O_COUNT=2, O_READY=0, O_DATA=0xA. Then raise I_READY: 0xA then 0xB appear, O_READY returns to 1, no loss or duplication.
- Bubble zeroing: I_CTRL=0xFFFFF with one valid entry, then I_VALID=0 and I_READY=1. Required: O_CTRL=0xFFFFF for one cycle, then 0x00000 with O_VALID=0.
- Flush with simultaneous events: COUNT=2, then FLUSH=1, I_VALID=1 and I_READY=1 in the same cycle. Required: next cycle O_VALID=0, O_COUNT=0, O_READY=1; the incoming entry never appears.
- SKID=0 mode: I_READY=0 with main full. Required: O_READY=0 in the same cycle. Toggle I_READY=1: O_READY=1 combinationally and accept/consume happen in the same edge.
- Random valid/ready soak, 10k cycles, both SKID values: a scoreboard confirms in-order, lossless delivery, and O_CTRL==0 whenever O_VALID=0.
